// File: rtl/mem_bus_responder_pkg.sv
// Shared types and default widths for the en/wr/addr command bus responder.
// Imported by the RTL and by the stimulus side of the bench.
package mem_bus_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 8;
    localparam int LEN_W_DEF  = 8;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_BURST = 2'd2
    } burst_state_e;

    typedef struct packed {
        logic                  en;
        logic                  wr;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/mem_bus_responder_if.sv
// Command/response bus between an initiator (master) and the register-memory target (slave).
interface mem_bus_if #(
    parameter int ADDR_W = mem_bus_pkg::ADDR_W_DEF,
    parameter int DATA_W = mem_bus_pkg::DATA_W_DEF
);
    logic              en;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;

    modport master (
        output en, wr, addr, wdata,
        input  rdata, rvalid
    );

    modport slave (
        input  en, wr, addr, wdata,
        output rdata, rvalid
    );
endinterface

// File: rtl/mem_bus_responder_burst_tracker.sv
// Groups consecutive same-direction beats into bursts and reports each one as it closes.
// Address is irrelevant here; only en/wr drive the grouping.
module burst_tracker
    import mem_bus_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wr,
    output logic             burst_done,
    output logic             burst_is_wr,
    output logic [LEN_W-1:0] burst_len
);

    localparam logic [LEN_W-1:0] LEN_MAX = '1;
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    burst_state_e     state_reg, state_next;
    logic [LEN_W-1:0] beat_reg, beat_next;
    logic             done_reg, done_next;
    logic             is_wr_reg, is_wr_next;
    logic [LEN_W-1:0] len_reg, len_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            beat_reg  <= '0;
            done_reg  <= 1'b0;
            is_wr_reg <= 1'b0;
            len_reg   <= '0;
        end else begin
            state_reg <= state_next;
            beat_reg  <= beat_next;
            done_reg  <= done_next;
            is_wr_reg <= is_wr_next;
            len_reg   <= len_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        beat_next  = beat_reg;
        done_next  = 1'b0;
        is_wr_next = is_wr_reg;
        len_next   = len_reg;

        unique case (state_reg)
            IDLE: begin
                if (en) begin
                    state_next = wr ? WR_BURST : RD_BURST;
                    beat_next  = LEN_ONE;
                end
            end
            WR_BURST, RD_BURST: begin
                if (en && (wr == (state_reg == WR_BURST))) begin
                    // Beat count sticks at its maximum while the burst stays open.
                    if (beat_reg != LEN_MAX) beat_next = beat_reg + LEN_ONE;
                end else begin
                    done_next  = 1'b1;
                    is_wr_next = (state_reg == WR_BURST);
                    len_next   = beat_reg;
                    if (en) begin
                        state_next = wr ? WR_BURST : RD_BURST;
                        beat_next  = LEN_ONE;
                    end else begin
                        state_next = IDLE;
                        beat_next  = '0;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                beat_next  = '0;
            end
        endcase
    end

    assign burst_done  = done_reg;
    assign burst_is_wr = is_wr_reg;
    assign burst_len   = len_reg;

endmodule

// File: rtl/mem_bus_responder.sv
// Target end of the command bus: local register memory with a registered read path,
// burst reporting and saturating read/write beat counters.
module mem_bus_responder
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    mem_bus_if.slave         bus,
    output logic             burst_done,
    output logic             burst_is_wr,
    output logic [LEN_W-1:0] burst_len,
    output logic [CNT_W-1:0] wr_count,
    output logic [CNT_W-1:0] rd_count
);

    localparam int DEPTH = 1 << ADDR_W;

    // 2-state storage so contents power up as zero; reset deliberately leaves it alone.
    bit   [DATA_W-1:0] mem_reg [DEPTH];
    logic [DATA_W-1:0] rdata_reg;
    logic              rvalid_reg;

    logic wr_beat;
    logic rd_beat;
    assign wr_beat = bus.en && bus.wr;
    assign rd_beat = bus.en && !bus.wr;

    always_ff @(posedge clk) begin
        if (wr_beat) mem_reg[bus.addr] <= bus.wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_reg  <= '0;
            rvalid_reg <= 1'b0;
        end else begin
            rvalid_reg <= rd_beat;
            if (rd_beat) rdata_reg <= mem_reg[bus.addr];
        end
    end

    assign bus.rdata  = rdata_reg;
    assign bus.rvalid = rvalid_reg;

    // Index 0 counts write beats, index 1 read beats.
    logic [1:0]            beat_hit;
    logic [1:0][CNT_W-1:0] beat_count;
    assign beat_hit = {rd_beat, wr_beat};

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_reg;
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_reg <= '0;
            end else if (beat_hit[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
        assign beat_count[gi] = cnt_reg;
    end

    assign wr_count = beat_count[0];
    assign rd_count = beat_count[1];

    burst_tracker #(
        .LEN_W(LEN_W)
    ) u_burst_tracker (
        .clk        (clk),
        .rst        (rst),
        .en         (bus.en),
        .wr         (bus.wr),
        .burst_done (burst_done),
        .burst_is_wr(burst_is_wr),
        .burst_len  (burst_len)
    );

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: a transaction-level model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_mem_bus_responder;
    import mem_bus_pkg::*;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;
    localparam int LEN_W  = 8;
    localparam int CNT_W  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic             burst_done;
    logic             burst_is_wr;
    logic [LEN_W-1:0] burst_len;
    logic [CNT_W-1:0] wr_count;
    logic [CNT_W-1:0] rd_count;

    mem_bus_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_bus_responder #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .burst_done (burst_done),
        .burst_is_wr(burst_is_wr),
        .burst_len  (burst_len),
        .wr_count   (wr_count),
        .rd_count   (rd_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;
    int done_seen = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Transaction-level model: memory array, current burst direction and unbounded beat tally.
    bit [DATA_W-1:0] m_mem [64];
    int m_rdata = 0, m_rvalid = 0, m_done = 0, m_is_wr = 0, m_len = 0;
    int m_wr = 0, m_rd = 0;
    int cur_dir = 0;   // 0 none, 1 write, 2 read
    int cur_beats = 0;

    always @(posedge clk) begin
        int new_dir;
        if (rst) begin
            m_rdata = 0; m_rvalid = 0; m_done = 0; m_is_wr = 0; m_len = 0;
            m_wr = 0; m_rd = 0; cur_dir = 0; cur_beats = 0;
        end else begin
            m_done   = 0;
            m_rvalid = 0;
            if (bus.en && !bus.wr) begin
                m_rdata  = int'(m_mem[bus.addr]);
                m_rvalid = 1;
                if (m_rd < 65535) m_rd++;
            end
            if (bus.en && bus.wr) begin
                m_mem[bus.addr] = bus.wdata;
                if (m_wr < 65535) m_wr++;
            end
            new_dir = bus.en ? (bus.wr ? 1 : 2) : 0;
            if (cur_dir != 0 && new_dir != cur_dir) begin
                m_done  = 1;
                m_is_wr = (cur_dir == 1) ? 1 : 0;
                m_len   = (cur_beats > 255) ? 255 : cur_beats;
            end
            if (new_dir == cur_dir) cur_beats++;
            else cur_beats = (new_dir != 0) ? 1 : 0;
            cur_dir = new_dir;
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            check("rvalid", int'(bus.rvalid), m_rvalid);
            check("rdata", int'(bus.rdata), m_rdata);
            check("burst_done", int'(burst_done), m_done);
            if (m_done != 0) begin
                check("burst_is_wr", int'(burst_is_wr), m_is_wr);
                check("burst_len", int'(burst_len), m_len);
            end
            check("wr_count", int'(wr_count), m_wr);
            check("rd_count", int'(rd_count), m_rd);
            if (burst_done) done_seen++;
        end
    end

    function automatic cmd_t mk(input bit e, input bit w, input int a, input int d);
        cmd_t c;
        c.en    = e;
        c.wr    = w;
        c.addr  = ADDR_W'(a);
        c.wdata = DATA_W'(d);
        return c;
    endfunction

    // Drive one command (called at a negedge); returns at the next negedge, after the edge sampled it.
    task automatic beat(input cmd_t c, input bit r = 1'b0);
        rst       = r;
        bus.en    = c.en;
        bus.wr    = c.wr;
        bus.addr  = c.addr;
        bus.wdata = c.wdata;
        $display("beat t=%0t rst=%0b en=%0b wr=%0b addr=%0d wdata=0x%02h", $time, r, c.en, c.wr, c.addr, c.wdata);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int d0;
        bus.en = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.wdata = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_rvalid", int'(bus.rvalid), 0);
        check("reset_wr_count", int'(wr_count), 0);
        check("reset_burst_len", int'(burst_len), 0);
        chk_on = 1'b1;

        // 1: two writes, two reads, idle
        beat(mk(1, 1, 12, 8'h11));
        beat(mk(1, 1, 14, 8'h22));
        beat(mk(1, 0, 23, 0));
        check("t1_done_wr", int'(burst_done), 1);
        check("t1_is_wr", int'(burst_is_wr), 1);
        check("t1_len_wr", int'(burst_len), 2);
        check("t1_rvalid3", int'(bus.rvalid), 1);
        check("t1_rdata3", int'(bus.rdata), 8'h00);
        beat(mk(1, 0, 48, 0));
        check("t1_rvalid4", int'(bus.rvalid), 1);
        check("t1_rdata4", int'(bus.rdata), 8'h00);
        beat(mk(0, 0, 0, 0));
        check("t1_done_rd", int'(burst_done), 1);
        check("t1_is_rd", int'(burst_is_wr), 0);
        check("t1_len_rd", int'(burst_len), 2);
        check("t1_wr_count", int'(wr_count), 2);
        check("t1_rd_count", int'(rd_count), 2);

        // 2: read-after-write on the next edge
        beat(mk(1, 1, 12, 8'hA5));
        beat(mk(1, 0, 12, 0));
        check("t2_rvalid", int'(bus.rvalid), 1);
        check("t2_rdata", int'(bus.rdata), 8'hA5);
        beat(mk(0, 0, 0, 0));

        // 3: address boundary, no aliasing
        beat(mk(1, 1, 63, 8'h3C));
        beat(mk(1, 1, 0, 8'h7E));
        beat(mk(1, 0, 63, 0));
        check("t3_rdata63", int'(bus.rdata), 8'h3C);
        beat(mk(1, 0, 0, 0));
        check("t3_rdata0", int'(bus.rdata), 8'h7E);
        beat(mk(0, 0, 0, 0));

        // 4: long write burst saturates length
        beat(mk(0, 0, 0, 0), 1'b1);
        d0 = done_seen;
        for (int i = 0; i < 300; i++) beat(mk(1, 1, i % 64, i));
        beat(mk(0, 0, 0, 0));
        check("t4_done", int'(burst_done), 1);
        check("t4_len", int'(burst_len), 255);
        check("t4_wr_count", int'(wr_count), 300);
        beat(mk(0, 0, 0, 0));
        check("t4_done_once", done_seen - d0, 1);

        // 5: reset in the third beat of a read burst
        beat(mk(1, 1, 5, 8'h5A));
        beat(mk(0, 0, 0, 0));
        beat(mk(1, 0, 1, 0));
        beat(mk(1, 0, 2, 0));
        d0 = done_seen;
        beat(mk(1, 0, 3, 0), 1'b1);
        check("t5_rvalid", int'(bus.rvalid), 0);
        check("t5_done", int'(burst_done), 0);
        check("t5_wr_count", int'(wr_count), 0);
        check("t5_rd_count", int'(rd_count), 0);
        beat(mk(0, 0, 0, 0));
        beat(mk(0, 0, 0, 0));
        check("t5_no_done", done_seen - d0, 0);
        beat(mk(1, 0, 5, 0));
        check("t5_mem_kept", int'(bus.rdata), 8'h5A);
        beat(mk(0, 0, 0, 0));

        // 6: alternating direction every beat
        beat(mk(0, 0, 0, 0));
        beat(mk(1, 1, 7, 8'h01));
        check("t6_open", int'(burst_done), 0);
        beat(mk(1, 0, 7, 0));
        check("t6_done1", int'(burst_done), 1);
        check("t6_wr1", int'(burst_is_wr), 1);
        check("t6_len1", int'(burst_len), 1);
        beat(mk(1, 1, 8, 8'h02));
        check("t6_done2", int'(burst_done), 1);
        check("t6_wr2", int'(burst_is_wr), 0);
        check("t6_len2", int'(burst_len), 1);
        beat(mk(1, 0, 8, 0));
        check("t6_done3", int'(burst_done), 1);
        check("t6_wr3", int'(burst_is_wr), 1);
        check("t6_len3", int'(burst_len), 1);
        beat(mk(0, 0, 0, 0));
        check("t6_done4", int'(burst_done), 1);
        check("t6_wr4", int'(burst_is_wr), 0);
        check("t6_len4", int'(burst_len), 1);
        beat(mk(0, 0, 0, 0));
        check("t6_quiet", int'(burst_done), 0);

        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
